// File: rtl/lieat_sram_rdarb.sv
// Two-master read arbiter sharing one SRAM AR/R port between I-cache (m0) and D-cache (m1).
// One outstanding read; registered address issue, combinational R steering to the owner.
`ifndef XLEN
`define XLEN 32
`endif

module lieat_sram_rdarb #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [`XLEN-1:0]  m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [`XLEN-1:0]  m0_rdata,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [`XLEN-1:0]  m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [`XLEN-1:0]  m1_rdata,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [`XLEN-1:0]  s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [`XLEN-1:0]  s_rdata,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {INIT, IDLE, ADDR, DATA} state_t;

    state_t state;
    state_t state_nx;
    logic   last;
    logic   prefer0;
    logic   gnt0;
    logic   gnt1;
    logic   ar_hs;

    // last==1 means master 1 was granted most recently, so master 0 is preferred next
    assign prefer0 = (PRIO_MODE == 1) ? 1'b1 : last;
    assign gnt0    = m0_arvalid & (~m1_arvalid | prefer0);
    assign gnt1    = m1_arvalid & ~gnt0;
    assign ar_hs   = (state == IDLE) & (gnt0 | gnt1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT: state_nx = IDLE;
            IDLE: if (ar_hs) state_nx = ADDR;
            ADDR: if (s_arvalid & s_arready) state_nx = DATA;
            DATA: if (s_rvalid & s_rready) state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        m0_arready = (state == IDLE) & gnt0;
        m1_arready = (state == IDLE) & gnt1;
        m0_rdata   = '0;
        m0_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rvalid  = 1'b0;
        s_rready   = 1'b0;
        if (state == DATA) begin
            if (owner) begin
                m1_rdata  = s_rdata;
                m1_rvalid = s_rvalid;
                s_rready  = m1_rready;
            end else begin
                m0_rdata  = s_rdata;
                m0_rvalid = s_rvalid;
                s_rready  = m0_rready;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_araddr  <= '0;
            s_arvalid <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
        end else if (ar_hs) begin
            s_araddr  <= gnt1 ? m1_araddr : m0_araddr;
            s_arvalid <= 1'b1;
            owner     <= gnt1;
            last      <= gnt1;
        end else if (s_arvalid & s_arready) begin
            s_arvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lieat_sram_rdarb.sv
// Bench for lieat_sram_rdarb: vector table of complete reads with a data scoreboard,
// plus hand-written reset, mid-transaction reset and fixed-priority sequences.
`ifndef XLEN
`define XLEN 32
`endif

module tb_lieat_sram_rdarb;

    logic              clk = 1'b0;
    logic              rstn;
    logic [`XLEN-1:0]  m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
    logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic              s_arvalid, s_arready, s_rvalid, s_rready, busy, owner;

    logic              p_rstn;
    logic [`XLEN-1:0]  p_m0_araddr, p_m1_araddr, p_m0_rdata, p_m1_rdata, p_s_araddr, p_s_rdata;
    logic              p_m0_arvalid, p_m0_arready, p_m0_rvalid, p_m0_rready;
    logic              p_m1_arvalid, p_m1_arready, p_m1_rvalid, p_m1_rready;
    logic              p_s_arvalid, p_s_arready, p_s_rvalid, p_s_rready, p_busy, p_owner;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit               v0;
        bit               v1;
        logic [`XLEN-1:0] a0;
        logic [`XLEN-1:0] a1;
        logic [`XLEN-1:0] data;
        int               exp_w;
        int               ar_wait;
        int               r_wait;
        int               rr_wait;
    } vec_t;

    typedef struct {
        int               w;
        logic [`XLEN-1:0] data;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    lieat_sram_rdarb #(.PRIO_MODE(0)) dut (
        .clk(clk), .rstn(rstn),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy), .owner(owner)
    );

    lieat_sram_rdarb #(.PRIO_MODE(1)) dut_p (
        .clk(clk), .rstn(p_rstn),
        .m0_araddr(p_m0_araddr), .m0_arvalid(p_m0_arvalid), .m0_arready(p_m0_arready),
        .m0_rdata(p_m0_rdata), .m0_rvalid(p_m0_rvalid), .m0_rready(p_m0_rready),
        .m1_araddr(p_m1_araddr), .m1_arvalid(p_m1_arvalid), .m1_arready(p_m1_arready),
        .m1_rdata(p_m1_rdata), .m1_rvalid(p_m1_rvalid), .m1_rready(p_m1_rready),
        .s_araddr(p_s_araddr), .s_arvalid(p_s_arvalid), .s_arready(p_s_arready),
        .s_rdata(p_s_rdata), .s_rvalid(p_s_rvalid), .s_rready(p_s_rready),
        .busy(p_busy), .owner(p_owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        int               aw;
        logic [`XLEN-1:0] ad;
        exp_t             e;
        aw = -1;
        ad = '0;
        if (m0_rvalid && m0_rready) begin
            aw = 0;
            ad = m0_rdata;
        end else if (m1_rvalid && m1_rready) begin
            aw = 1;
            ad = m1_rdata;
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk("r_master", 64'(aw), 64'(e.w));
            chk("r_data", 64'(ad), 64'(e.data));
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, output int gcyc);
        bit               granted;
        logic [`XLEN-1:0] exp_addr;
        gcyc       = -1;
        granted    = 1'b0;
        exp_addr   = (v.exp_w == 1) ? v.a1 : v.a0;
        m0_arvalid = v.v0;
        m1_arvalid = v.v1;
        m0_araddr  = v.a0;
        m1_araddr  = v.a1;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        for (int i = 0; i < 8 && !granted; i++) begin
            @(negedge clk);
            if (m0_arready || m1_arready) granted = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!granted) begin
            chk("grant_timeout", 64'(granted), 64'd1);
            return;
        end
        chk("grant", {m1_arready, m0_arready}, (v.exp_w == 1) ? 64'd2 : 64'd1);
        chk("idle_busy", busy, 0);
        gcyc = cyc;
        sb.push_back('{w: v.exp_w, data: v.data});
        @(posedge clk); #1;
        for (int i = 0; i <= v.ar_wait; i++) begin
            s_arready = (i == v.ar_wait);
            s_rvalid  = 1'b1;
            s_rdata   = 32'hBAD0_0000 ^ 32'(i);
            @(negedge clk);
            chk("s_arvalid", s_arvalid, 1);
            chk("s_araddr", s_araddr, exp_addr);
            chk("owner", owner, 64'(v.exp_w));
            chk("addr_no_arready", {m1_arready, m0_arready}, 0);
            chk("addr_r_blocked", {s_rready, m1_rvalid, m0_rvalid}, 0);
            @(posedge clk); #1;
        end
        s_arready = 1'b0;
        for (int i = 0; i < v.r_wait; i++) begin
            s_rvalid = 1'b0;
            @(negedge clk);
            chk("data_wait_rvalid", {m1_rvalid, m0_rvalid}, 0);
            chk("s_arvalid_clr", s_arvalid, 0);
            @(posedge clk); #1;
        end
        s_rvalid = 1'b1;
        s_rdata  = v.data;
        for (int i = 0; i <= v.rr_wait; i++) begin
            if (v.exp_w == 1) m1_rready = (i == v.rr_wait);
            else              m0_rready = (i == v.rr_wait);
            @(negedge clk);
            chk("s_rready", s_rready, 64'(i == v.rr_wait));
            chk("non_owner_r", (v.exp_w == 1) ? {m0_rvalid, m0_rdata} : {m1_rvalid, m1_rdata}, 0);
            chk("data_no_arready", {m1_arready, m0_arready}, 0);
            chk("data_busy", busy, 1);
            if (i == v.rr_wait) sb_check();
            else chk("owner_rvalid", (v.exp_w == 1) ? m1_rvalid : m0_rvalid, 1);
            @(posedge clk); #1;
        end
        s_rvalid  = 1'b0;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, prev, n0, n1;
        vec_t mv;

        //         v0 v1 a0            a1            data          w  arw rw rrw
        vecs[0]  = '{1, 1, 32'h8000_0000, 32'h9000_0000, 32'hDEAD_BEEF, 0, 0, 1, 0};
        vecs[1]  = '{0, 1, 32'h0,         32'h9000_0010, 32'h1111_0001, 1, 0, 0, 0};
        vecs[2]  = '{1, 1, 32'h8000_0020, 32'h9000_0020, 32'h2222_0000, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 32'h8000_0030, 32'h9000_0030, 32'h3333_0001, 1, 0, 0, 0};
        vecs[4]  = '{1, 1, 32'h8000_0040, 32'h9000_0040, 32'h4444_0000, 0, 0, 0, 0};
        vecs[5]  = '{1, 1, 32'h8000_0050, 32'h9000_0050, 32'h5555_0001, 1, 0, 0, 0};
        vecs[6]  = '{0, 1, 32'h0,         32'h9000_0060, 32'h6666_0001, 1, 3, 0, 2};
        vecs[7]  = '{0, 1, 32'h0,         32'h9000_0070, 32'h7777_0001, 1, 0, 1, 0};
        vecs[8]  = '{0, 1, 32'h0,         32'h9000_0080, 32'h8888_0001, 1, 1, 0, 1};
        vecs[9]  = '{1, 0, 32'h8000_0090, 32'h0,         32'h9999_0000, 0, 0, 2, 0};
        vecs[10] = '{1, 0, 32'h8000_00A0, 32'h0,         32'hAAAA_0000, 0, 0, 0, 0};
        vecs[11] = '{1, 1, 32'h8000_00B0, 32'h9000_00B0, 32'hBBBB_0001, 1, 0, 0, 0};

        rstn = 1'b0; p_rstn = 1'b0;
        m0_araddr = '0; m1_araddr = '0; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        p_m0_araddr = 32'h0000_1000; p_m1_araddr = 32'h0000_2000;
        p_m0_arvalid = 1'b1; p_m1_arvalid = 1'b1; p_m0_rready = 1'b1; p_m1_rready = 1'b1;
        p_s_arready = 1'b1; p_s_rvalid = 1'b1; p_s_rdata = 32'hC0DE_0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", {m1_arready, m0_arready}, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_busy", busy, 1);
        chk("rst_owner", owner, 0);
        chk("rst_r_path", {s_rready, m1_rvalid, m0_rvalid}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("init_arready", {m1_arready, m0_arready}, 0);
        chk("init_busy", busy, 1);
        @(posedge clk); #1;

        prev = -1;
        for (int k = 0; k < 12; k++) begin
            run_vec(vecs[k], g);
            if (k >= 2 && k <= 5) chk("rr_throughput", 64'(g - prev), 64'd3);
            prev = g;
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;

        // Reset while the R beat is being accepted.
        m0_araddr  = 32'h1234_5678;
        m0_arvalid = 1'b1;
        @(negedge clk);
        chk("mr_grant", {m1_arready, m0_arready}, 1);
        @(posedge clk); #1;
        m0_arvalid = 1'b0;
        s_arready  = 1'b1;
        @(posedge clk); #1;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hFEED_F00D;
        @(negedge clk);
        chk("mr_pre_s_rready", s_rready, 1);
        chk("mr_pre_m0_rvalid", m0_rvalid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mr_s_rready", s_rready, 0);
        chk("mr_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("mr_s_arvalid", s_arvalid, 0);
        chk("mr_busy_owner", {busy, owner}, 2);
        s_rvalid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_init_arready", {m1_arready, m0_arready}, 0);
        @(posedge clk); #1;
        mv = '{0, 1, 32'h0, 32'h9000_0F00, 32'h0F0F_0001, 1, 0, 1, 0};
        run_vec(mv, g);
        chk("sb_drained", 64'(sb.size()), 0);

        // Fixed priority: both masters request continuously.
        n0 = 0;
        n1 = 0;
        p_rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (p_m0_arready) n0++;
            if (p_m1_arready) n1++;
            @(posedge clk); #1;
        end
        chk("prio_m1_grants", 64'(n1), 0);
        chk("prio_m0_grants", 64'(n0), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
